// File: rtl/pipe_mem_pkg.sv
// Shared types and constants for the pipeline memory arbiter.
//   owner_t            : which requester owns the read data returning next cycle
//   CONFLICT_CNT_W     : width of the saturating conflict counter
//   STARVE_MAX_DEFAULT : default number of consecutive fetch losses before fetch is forced
//   STARVE_CNT_W       : width of the fetch starvation counter
//   sat_inc_conflict() : saturating increment for the conflict counter
package pipe_mem_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_IF   = 2'd1,
    OWNER_DM   = 2'd2
  } owner_t;

  localparam int CONFLICT_CNT_W     = 8;
  localparam int STARVE_MAX_DEFAULT = 4;
  localparam int STARVE_CNT_W       = 4;

  function automatic logic [CONFLICT_CNT_W-1:0] sat_inc_conflict(
    input logic [CONFLICT_CNT_W-1:0] v
  );
    if (v == {CONFLICT_CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + CONFLICT_CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/pipe_mem_arbiter_if.sv
// Bus bundle between the datapath/memory side and the arbiter.
//   fetch side : if_req, if_addr, flush -> if_stall, if_valid, if_rdata
//   data side  : dm_req, dm_we, dm_addr, dm_wdata -> dm_stall, dm_valid, dm_rdata
//   memory port: mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata (one cycle later)
//   status     : conflict_cnt
// Modports: master = datapath plus memory (drives requests and mem_rdata),
//           slave  = the arbiter.
interface pipe_mem_arbiter_if
  import pipe_mem_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic                      if_req;
  logic [AW-1:0]             if_addr;
  logic                      if_stall;
  logic                      if_valid;
  logic [DW-1:0]             if_rdata;
  logic                      flush;
  logic                      dm_req;
  logic                      dm_we;
  logic [AW-1:0]             dm_addr;
  logic [DW-1:0]             dm_wdata;
  logic                      dm_stall;
  logic                      dm_valid;
  logic [DW-1:0]             dm_rdata;
  logic                      mem_en;
  logic                      mem_we;
  logic [AW-1:0]             mem_addr;
  logic [DW-1:0]             mem_wdata;
  logic [DW-1:0]             mem_rdata;
  logic [CONFLICT_CNT_W-1:0] conflict_cnt;

  modport master (
    output if_req, if_addr, flush, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_stall, if_valid, if_rdata, dm_stall, dm_valid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, conflict_cnt
  );

  modport slave (
    input  if_req, if_addr, flush, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_stall, if_valid, if_rdata, dm_stall, dm_valid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, conflict_cnt
  );
endinterface

// File: rtl/arb_starve_counter.sv
// Fetch starvation guard. Counts consecutive cycles in which fetch was stalled
// because data won the port, and raises force_if once the count reaches
// STARVE_MAX so the next contended cycle goes to fetch.
//   clk, rst_n     : clock, asynchronous active-low reset
//   stalled_by_dm  : fetch requested but data was granted this cycle
//   if_grant       : fetch was granted this cycle (clears the count)
//   force_if       : fetch must win the next contended cycle
module arb_starve_counter
  import pipe_mem_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stalled_by_dm,
  input  logic if_grant,
  output logic force_if
);

  logic [STARVE_CNT_W-1:0] cnt_d, cnt_q;

  // Next count: clear on a fetch grant, saturating increment on a data-caused stall.
  always_comb begin
    cnt_d = cnt_q;
    if (if_grant) begin
      cnt_d = '0;
    end else if (stalled_by_dm && (cnt_q != {STARVE_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + STARVE_CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_if = (cnt_q == STARVE_CNT_W'(STARVE_MAX));

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and the
// data memory stage. One grant per cycle, data wins a conflict (it belongs to the
// older instruction). Read data returns one cycle after the grant and is routed
// to its owner; a fetch return is dropped when flush is seen in its grant or
// return cycle.
// Optional feature: define PIPE_ARB_STARVE_GUARD_EN to let fetch win a conflict
// after STARVE_MAX consecutive losses (arb_starve_counter).
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : pipe_mem_arbiter_if.slave (fetch, data, memory port, conflict_cnt)
module pipe_mem_arbiter
  import pipe_mem_pkg::*;
#(
  parameter int AW         = 8,
  parameter int DW         = 16,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  pipe_mem_arbiter_if.slave        bus
);

  if ((STARVE_MAX < 1) || (STARVE_MAX > 15)) begin : g_bad_starve_max
    $error("pipe_mem_arbiter: STARVE_MAX out of range 1..15");
  end

  logic                      if_grant_s;
  logic                      dm_grant_s;
  logic                      force_if_s;
  logic                      mem_en_s;
  logic                      mem_we_s;
  logic [AW-1:0]             mem_addr_s;
  logic [DW-1:0]             mem_wdata_s;
  logic                      if_valid_s;
  logic                      dm_valid_s;
  owner_t                    owner_d, owner_q;
  logic [DW-1:0]             if_rdata_d, if_rdata_q;
  logic [DW-1:0]             dm_rdata_d, dm_rdata_q;
  logic [CONFLICT_CNT_W-1:0] conflict_d, conflict_q;

`ifdef PIPE_ARB_STARVE_GUARD_EN
  arb_starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk           (clk),
    .rst_n         (reset),
    .stalled_by_dm (bus.if_req && dm_grant_s),
    .if_grant      (if_grant_s),
    .force_if      (force_if_s)
  );
`else
  assign force_if_s = 1'b0;
`endif

  // Grant: data wins unless the starvation guard forces fetch on a conflict.
  always_comb begin
    dm_grant_s = 1'b0;
    if_grant_s = 1'b0;
    if (bus.dm_req && !(bus.if_req && force_if_s)) begin
      dm_grant_s = 1'b1;
    end else if (bus.if_req) begin
      if_grant_s = 1'b1;
    end else begin
      dm_grant_s = 1'b0;
      if_grant_s = 1'b0;
    end
  end

  // Memory port mux: winner's signals, all zero when idle.
  always_comb begin
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = '0;
    mem_wdata_s = '0;
    if (dm_grant_s) begin
      mem_en_s    = 1'b1;
      mem_we_s    = bus.dm_we;
      mem_addr_s  = bus.dm_addr;
      mem_wdata_s = bus.dm_wdata;
    end else if (if_grant_s) begin
      mem_en_s    = 1'b1;
      mem_addr_s  = bus.if_addr;
    end else begin
      mem_en_s    = 1'b0;
    end
  end

  // Owner of next cycle's read data. A fetch flushed in its grant cycle is
  // recorded as NONE so its return can never be delivered.
  always_comb begin
    owner_d = OWNER_NONE;
    if (dm_grant_s) begin
      owner_d = bus.dm_we ? OWNER_NONE : OWNER_DM;
    end else if (if_grant_s) begin
      owner_d = bus.flush ? OWNER_NONE : OWNER_IF;
    end else begin
      owner_d = OWNER_NONE;
    end
  end

  // Return routing; flush in the return cycle also kills a fetch return.
  // Read data is passed straight through on the valid cycle and held otherwise.
  always_comb begin
    if_valid_s = (owner_q == OWNER_IF) && !bus.flush;
    dm_valid_s = (owner_q == OWNER_DM);
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if (if_valid_s) begin
      if_rdata_d = bus.mem_rdata;
    end else begin
      if_rdata_d = if_rdata_q;
    end
    if (dm_valid_s) begin
      dm_rdata_d = bus.mem_rdata;
    end else begin
      dm_rdata_d = dm_rdata_q;
    end
  end

  // Conflict counter next value.
  always_comb begin
    conflict_d = conflict_q;
    if (bus.if_req && bus.dm_req) begin
      conflict_d = sat_inc_conflict(conflict_q);
    end else begin
      conflict_d = conflict_q;
    end
  end

  // State registers; reset drops any pending read return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q    <= OWNER_NONE;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      conflict_q <= '0;
    end else begin
      owner_q    <= owner_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus.mem_en       = mem_en_s;
  assign bus.mem_we       = mem_we_s;
  assign bus.mem_addr     = mem_addr_s;
  assign bus.mem_wdata    = mem_wdata_s;
  assign bus.if_stall     = bus.if_req && !if_grant_s;
  assign bus.dm_stall     = bus.dm_req && !dm_grant_s;
  assign bus.if_valid     = if_valid_s;
  assign bus.dm_valid     = dm_valid_s;
  assign bus.if_rdata     = if_rdata_d;
  assign bus.dm_rdata     = dm_rdata_d;
  assign bus.conflict_cnt = conflict_q;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Self-checking bench for pipe_mem_arbiter. A reference model of the grant and
// memory contents pushes the expected return of each cycle into a queue; the
// entry is popped and compared on the following cycle.
module tb_pipe_mem_arbiter;
  import pipe_mem_pkg::*;

  localparam int STARVE_MAX = 4;

  typedef struct packed {
    owner_t      own;
    logic [15:0] data;
  } ret_t;

  logic clk;
  logic reset;
  int   err_cnt;
  int   chk_cnt;
  int   if_grants;

  pipe_mem_arbiter_if #(.AW(8), .DW(16)) bus ();

  pipe_mem_arbiter #(
    .AW         (8),
    .DW         (16),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input int a);
    logic [7:0] b;
    b = 8'(a);
    if (a == 0)         return 16'hA1B2;
    else if (a == 16)   return 16'h0042;
    else if (a == 5)    return 16'h5A5A;
    else                return {b ^ 8'h3C, b};
  endfunction

  // Environment memory: synchronous single port, read data one cycle later.
  logic [15:0] mem [256];
  logic [15:0] mem_rdata_r;
  logic        mem_loaded;
  initial mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_rdata_r <= 16'h0000;
      mem_loaded  <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            mem_rdata_r <= mem[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = mem_rdata_r;

  // Reference model state.
  logic [15:0] ref_mem [256];
  ret_t        exp_q [$];
  logic [15:0] m_if_rdata;
  logic [15:0] m_dm_rdata;
  int          m_conflict;
  int          m_starve;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_if_rdata = 16'h0000;
    m_dm_rdata = 16'h0000;
    m_conflict = 0;
    m_starve   = 0;
  endtask

  task automatic set_idle();
    bus.if_req   = 1'b0;
    bus.if_addr  = 8'h00;
    bus.flush    = 1'b0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = 8'h00;
    bus.dm_wdata = 16'h0000;
  endtask

  // One clock cycle, entered and left at posedge+1.
  task automatic step(input logic ifr, input logic [7:0] ia, input logic fl,
                      input logic dr, input logic dw, input logic [7:0] da,
                      input logic [15:0] wd);
    ret_t        r;
    logic        force_if;
    logic        e_ifg, e_dmg, e_en, e_we;
    logic [7:0]  e_addr;
    logic [15:0] e_wd;
    bus.if_req   = ifr;
    bus.if_addr  = ia;
    bus.flush    = fl;
    bus.dm_req   = dr;
    bus.dm_we    = dw;
    bus.dm_addr  = da;
    bus.dm_wdata = wd;
    @(negedge clk);
    // Return from the previous cycle's grant.
    if (exp_q.size() > 0) r = exp_q.pop_front();
    else                  r = '{OWNER_NONE, 16'h0000};
    if ((r.own == OWNER_IF) && !fl) m_if_rdata = r.data;
    if (r.own == OWNER_DM)          m_dm_rdata = r.data;
    check_eq("if_valid", 32'(bus.if_valid), 32'((r.own == OWNER_IF) && !fl));
    check_eq("dm_valid", 32'(bus.dm_valid), 32'(r.own == OWNER_DM));
    check_eq("if_rdata", 32'(bus.if_rdata), 32'(m_if_rdata));
    check_eq("dm_rdata", 32'(bus.dm_rdata), 32'(m_dm_rdata));
    check_eq("conflict_cnt", 32'(bus.conflict_cnt), 32'(m_conflict));
    // Grant of this cycle.
    force_if = 1'b0;
`ifdef PIPE_ARB_STARVE_GUARD_EN
    force_if = (m_starve == STARVE_MAX);
`endif
    e_dmg  = dr && !(ifr && force_if);
    e_ifg  = ifr && !e_dmg;
    e_en   = e_dmg || e_ifg;
    e_we   = e_dmg && dw;
    e_addr = e_dmg ? da : (e_ifg ? ia : 8'h00);
    e_wd   = e_dmg ? wd : 16'h0000;
    check_eq("if_stall", 32'(bus.if_stall), 32'(ifr && !e_ifg));
    check_eq("dm_stall", 32'(bus.dm_stall), 32'(dr && !e_dmg));
    check_eq("mem_en", 32'(bus.mem_en), 32'(e_en));
    check_eq("mem_we", 32'(bus.mem_we), 32'(e_we));
    check_eq("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
    check_eq("mem_wdata", 32'(bus.mem_wdata), 32'(e_wd));
    if (bus.if_req && !bus.if_stall) if_grants++;
    if (e_ifg)              exp_q.push_back('{(fl ? OWNER_NONE : OWNER_IF), ref_mem[ia]});
    else if (e_dmg && !dw)  exp_q.push_back('{OWNER_DM, ref_mem[da]});
    else                    exp_q.push_back('{OWNER_NONE, 16'h0000});
    if (e_dmg && dw) ref_mem[da] = wd;
    if (ifr && dr && (m_conflict < 255)) m_conflict++;
    if (e_ifg) m_starve = 0;
    else if (ifr && e_dmg && (m_starve < 15)) m_starve++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
  endtask

  task automatic apply_reset();
    set_idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    err_cnt   = 0;
    chk_cnt   = 0;
    if_grants = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    model_reset();
    set_idle();
    reset       = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    // Reset state: registered outputs cleared, grant path follows inputs.
    check_eq("rst_if_valid", 32'(bus.if_valid), 32'd0);
    check_eq("rst_dm_valid", 32'(bus.dm_valid), 32'd0);
    check_eq("rst_if_rdata", 32'(bus.if_rdata), 32'd0);
    check_eq("rst_dm_rdata", 32'(bus.dm_rdata), 32'd0);
    check_eq("rst_conflict", 32'(bus.conflict_cnt), 32'd0);
    check_eq("rst_mem_en", 32'(bus.mem_en), 32'd1);
    reset = 1'b1;

    // Fetch right after reset release.
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    idle_step();
    check_eq("tp1_if_rdata", 32'(bus.if_rdata), 32'h0000_A1B2);

    // Conflict: data load wins, fetch stalls.
    step(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h10, 16'h0000);
    idle_step();
    check_eq("tp2_dm_rdata", 32'(bus.dm_rdata), 32'h0000_0042);
    check_eq("tp2_conflict", 32'(bus.conflict_cnt), 32'd1);

    // Store concurrent with fetch, fetch next cycle, then load back.
    step(1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h20, 16'h00FF);
    step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h20, 16'h0000);
    idle_step();
    check_eq("tp3_dm_rdata", 32'(bus.dm_rdata), 32'h0000_00FF);

    // Flush in the return cycle, then flush in the grant cycle.
    step(1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    check_eq("tp4_if_rdata_held", 32'(bus.if_rdata), 32'(init_val(2)));
    step(1'b1, 8'h06, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    idle_step();

    // Mixed random traffic, back-to-back grants.
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 63)), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
           8'($urandom_range(48, 63)), 16'($urandom_range(0, 65535)));
    end
    idle_step();

    // Continuous contention from a clean starvation counter.
    apply_reset();
    if_grants = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'h08, 1'b0, 1'b1, 1'b0, 8'(8'h10 + i), 16'h0000);
    end
`ifdef PIPE_ARB_STARVE_GUARD_EN
    check_eq("starve_if_grants", 32'(if_grants), 32'd2);
`else
    check_eq("starve_if_grants", 32'(if_grants), 32'd0);
`endif

    // Conflict counter saturation.
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 8'h09, 1'b0, 1'b1, 1'b0, 8'h11, 16'h0000);
    end
    idle_step();
    check_eq("sat_conflict", 32'(bus.conflict_cnt), 32'd255);

    // Asynchronous reset with a data read pending.
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h10, 16'h0000);
    check_eq("pre_rst_dm_valid", 32'(bus.dm_valid), 32'd1);
    set_idle();
    reset = 1'b0;
    #1;
    check_eq("async_rst_dm_valid", 32'(bus.dm_valid), 32'd0);
    check_eq("async_rst_if_valid", 32'(bus.if_valid), 32'd0);
    check_eq("async_rst_dm_rdata", 32'(bus.dm_rdata), 32'd0);
    check_eq("async_rst_conflict", 32'(bus.conflict_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    idle_step();
    idle_step();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
